// File: rtl/rifl_pkg.sv
// Shared RIFL definitions: frame headers, idle control code, frame-type and
// scheduler-state encodings.
package rifl_pkg;

  localparam logic [1:0] HDR_DATA  = 2'b01;
  localparam logic [1:0] HDR_CTRL  = 2'b10;
  localparam int unsigned CTRL_IDLE = '0;

  typedef enum logic [1:0] {FT_IDLE, FT_DATA, FT_CTRL} frame_type_e;
  typedef enum logic {ST_OFF, ST_RUN} state_e;

  // Idle frames reuse the control header with the reserved zero code.
  function automatic logic [1:0] frame_hdr(input frame_type_e ft);
    return (ft == FT_DATA) ? HDR_DATA : HDR_CTRL;
  endfunction

endpackage

// File: rtl/rifl_frame_serializer.sv
// Frame load/shift register: emits a FRAME_WIDTH frame MSB-first as
// FRAME_WIDTH/DWIDTH beats, with sof on beat 0 and a beat index.
module rifl_frame_serializer #(
  parameter int FRAME_WIDTH = 256,
  parameter int DWIDTH      = 64,
  localparam int BEATS      = FRAME_WIDTH / DWIDTH,
  localparam int BCW        = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   advance,
  input  logic [FRAME_WIDTH-1:0] frame,
  output logic [DWIDTH-1:0]      beat,
  output logic                   sof,
  output logic [BCW-1:0]         bcnt
);
  import rifl_pkg::*;

  logic [FRAME_WIDTH-1:0] shreg;

  // shreg always holds the not-yet-emitted beats left-aligned; when neither
  // loading nor advancing the output bus is parked at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
      beat  <= '0;
      sof   <= 1'b0;
      bcnt  <= '0;
    end else if (load) begin
      shreg <= frame << DWIDTH;
      beat  <= frame[FRAME_WIDTH-1 -: DWIDTH];
      sof   <= 1'b1;
      bcnt  <= '0;
    end else if (advance) begin
      shreg <= shreg << DWIDTH;
      beat  <= shreg[FRAME_WIDTH-1 -: DWIDTH];
      sof   <= 1'b0;
      bcnt  <= bcnt + 1'b1;
    end else begin
      beat  <= '0;
      sof   <= 1'b0;
      bcnt  <= '0;
    end
  end

endmodule

// File: rtl/rifl_tx_frame_sched.sv
// RIFL TX frame scheduler: control > data > idle at each frame boundary.
// Optional statistics counters under RIFL_TX_SCHED_STATS_EN.
module rifl_tx_frame_sched #(
  parameter int FRAME_WIDTH = 256,
  parameter int DWIDTH      = 64,
  parameter int CRC_WIDTH   = 12,
  parameter int CTRL_W      = 8,
  localparam int PAYLOAD_W  = FRAME_WIDTH - 2 - CRC_WIDTH,
  localparam int BEATS      = FRAME_WIDTH / DWIDTH,
  localparam int BCW        = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_en,
  input  logic                 pause,
  input  logic [PAYLOAD_W-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 ctrl_req,
  input  logic [CTRL_W-1:0]    ctrl_code,
  output logic                 ctrl_ack,
  output logic                 sof_out,
  output logic [DWIDTH-1:0]    data_out,
  output logic                 busy,
`ifdef RIFL_TX_SCHED_STATS_EN
  output logic [31:0]          stat_data,
  output logic [31:0]          stat_ctrl,
  output logic [31:0]          stat_idle,
`endif
  output logic [0:0]           dbg_state
);
  import rifl_pkg::*;

  localparam logic [0:0] S_OFF = ST_OFF;
  localparam logic [0:0] S_RUN = ST_RUN;

  logic [0:0]             state, state_nxt;
  logic [BCW-1:0]         bcnt;
  logic                   last_beat;
  logic                   decide;
  logic                   stop;
  logic                   advance;
  frame_type_e            ft;
  logic [PAYLOAD_W-1:0]   payload;
  logic [FRAME_WIDTH-1:0] frame;

  assign last_beat = (bcnt == BCW'(BEATS - 1));
  assign decide    = rst_n && tx_en && ((state == S_OFF) || last_beat);
  assign stop      = (state == S_RUN) && last_beat && !tx_en;
  assign advance   = (state == S_RUN) && !last_beat;

  always_comb begin
    ft = FT_IDLE;
    if (ctrl_req)
      ft = FT_CTRL;
    else if (s_valid && !pause)
      ft = FT_DATA;
  end

  // Handshake: s_valid/ctrl_req are levels held by the source; a transfer
  // happens only in the decision cycle, when s_ready or ctrl_ack is high,
  // and the source drops or advances on the following edge.
  assign ctrl_ack = decide && (ft == FT_CTRL);
  assign s_ready  = decide && (ft == FT_DATA);

  always_comb begin
    payload = PAYLOAD_W'(CTRL_IDLE);
    case (ft)
      FT_DATA: payload = s_data;
      FT_CTRL: payload = PAYLOAD_W'(ctrl_code) << (PAYLOAD_W - CTRL_W);
      default: payload = PAYLOAD_W'(CTRL_IDLE);
    endcase
  end

  assign frame = {frame_hdr(ft), payload, {CRC_WIDTH{1'b0}}};

  always_comb begin
    state_nxt = state;
    if (decide)
      state_nxt = S_RUN;
    else if (stop)
      state_nxt = S_OFF;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_OFF;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == S_RUN);
    end
  end

  assign dbg_state = state;

  rifl_frame_serializer #(
    .FRAME_WIDTH(FRAME_WIDTH),
    .DWIDTH     (DWIDTH)
  ) u_ser (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (decide),
    .advance(advance),
    .frame  (frame),
    .beat   (data_out),
    .sof    (sof_out),
    .bcnt   (bcnt)
  );

`ifdef RIFL_TX_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_data <= '0;
      stat_ctrl <= '0;
      stat_idle <= '0;
    end else if (decide) begin
      case (ft)
        FT_DATA: stat_data <= stat_data + 32'd1;
        FT_CTRL: stat_ctrl <= stat_ctrl + 32'd1;
        default: stat_idle <= stat_idle + 32'd1;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_rifl_tx_frame_sched.sv
// Directed bench for rifl_tx_frame_sched (default 4-beat build plus a
// 1-beat instance); statistics checks when RIFL_TX_SCHED_STATS_EN is set.
module tb_rifl_tx_frame_sched;

  localparam int PW = 242;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, tx_en, pause, s_valid, s_ready, ctrl_req, ctrl_ack;
  logic [PW-1:0]   s_data;
  logic [7:0]      ctrl_code;
  logic            sof_out, busy;
  logic [63:0]     data_out;
  logic [0:0]      dbg_state;

  logic            rst_n1, tx_en1, pause1, s_valid1, s_ready1, ctrl_req1, ctrl_ack1;
  logic [PW-1:0]   s_data1;
  logic [7:0]      ctrl_code1;
  logic            sof_out1, busy1;
  logic [255:0]    data_out1;
  logic [0:0]      dbg_state1;

`ifdef RIFL_TX_SCHED_STATS_EN
  logic [31:0] stat_data, stat_ctrl, stat_idle;
  logic [31:0] stat_data1, stat_ctrl1, stat_idle1;
`endif

  rifl_tx_frame_sched u_dut (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .pause(pause),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ctrl_req(ctrl_req), .ctrl_code(ctrl_code), .ctrl_ack(ctrl_ack),
    .sof_out(sof_out), .data_out(data_out), .busy(busy),
`ifdef RIFL_TX_SCHED_STATS_EN
    .stat_data(stat_data), .stat_ctrl(stat_ctrl), .stat_idle(stat_idle),
`endif
    .dbg_state(dbg_state)
  );

  rifl_tx_frame_sched #(.DWIDTH(256)) u_dut1 (
    .clk(clk), .rst_n(rst_n1), .tx_en(tx_en1), .pause(pause1),
    .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
    .ctrl_req(ctrl_req1), .ctrl_code(ctrl_code1), .ctrl_ack(ctrl_ack1),
    .sof_out(sof_out1), .data_out(data_out1), .busy(busy1),
`ifdef RIFL_TX_SCHED_STATS_EN
    .stat_data(stat_data1), .stat_ctrl(stat_ctrl1), .stat_idle(stat_idle1),
`endif
    .dbg_state(dbg_state1)
  );

  // scoreboard
  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called in a decision cycle: drive the requests, check the acks, then
  // follow the four beats of the chosen frame back to the next boundary.
  task automatic send_frame(input string tag, input logic sv, input logic [PW-1:0] sd,
                            input logic cr, input logic [7:0] cc, input logic pz,
                            input logic hold, input logic exp_sr, input logic exp_ack,
                            input logic [63:0] b0, input logic [63:0] b1,
                            input logic [63:0] b2, input logic [63:0] b3);
    s_valid = sv; s_data = sd; ctrl_req = cr; ctrl_code = cc; pause = pz;
    #1;
    check({tag, "_s_ready"}, s_ready, exp_sr);
    check({tag, "_ctrl_ack"}, ctrl_ack, exp_ack);
    exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2); exp_q.push_back(b3);
    for (int k = 0; k < 4; k++) begin
      tick;
      if (k == 0) begin
        ctrl_req = 1'b0;
        if (!hold) s_valid = 1'b0;
      end
      check({tag, "_sof"}, sof_out, (k == 0));
      check({tag, "_beat"}, data_out, exp_q.pop_front());
      check({tag, "_busy"}, busy, 1'b1);
      if (k < 3) begin
        #1;
        check({tag, "_mid_s_ready"}, s_ready, 1'b0);
        check({tag, "_mid_ctrl_ack"}, ctrl_ack, 1'b0);
      end
    end
  endtask

  logic [PW-1:0]  ones, low1, top11;
  logic [255:0]   full_ones, full_idle;

  initial begin
    ones  = '1;
    low1  = PW'(1);
    top11 = PW'(3) << (PW - 2);
    full_ones = {2'b01, ones, 12'h000};
    full_idle = {2'b10, 254'h0};

    rst_n = 1'b0; tx_en = 1'b1; pause = 1'b0; s_valid = 1'b0; s_data = '0;
    ctrl_req = 1'b0; ctrl_code = '0;
    rst_n1 = 1'b0; tx_en1 = 1'b0; pause1 = 1'b0; s_valid1 = 1'b0; s_data1 = '0;
    ctrl_req1 = 1'b0; ctrl_code1 = '0;

    repeat (3) tick;
    check("rst_sof", sof_out, 1'b0);
    check("rst_data", data_out, 64'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, 1'b0);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_ctrl_ack", ctrl_ack, 1'b0);
`ifdef RIFL_TX_SCHED_STATS_EN
    check("rst_stat_data", stat_data, 32'd0);
`endif

    rst_n = 1'b1;
    send_frame("idle0", 1'b0, '0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0,
               64'h8000_0000_0000_0000, 64'h0, 64'h0, 64'h0);
    send_frame("data", 1'b1, ones, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0,
               64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_F000);
    send_frame("ctrl", 1'b1, low1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1,
               64'hA940_0000_0000_0000, 64'h0, 64'h0, 64'h0);
    send_frame("after_ctrl", 1'b1, low1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0,
               64'h4000_0000_0000_0000, 64'h0, 64'h0, 64'h0000_0000_0000_1000);

    for (int i = 0; i < 3; i++)
      send_frame("pause_idle", 1'b1, low1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0,
                 64'h8000_0000_0000_0000, 64'h0, 64'h0, 64'h0);
    send_frame("pause_ctrl", 1'b1, low1, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1,
               64'h8040_0000_0000_0000, 64'h0, 64'h0, 64'h0);
    send_frame("unpause", 1'b1, top11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0,
               64'h7000_0000_0000_0000, 64'h0, 64'h0, 64'h0);

    // tx_en dropped while beat 1 is on the bus
    s_valid = 1'b1; s_data = ones;
    #1;
    check("txoff_s_ready", s_ready, 1'b1);
    tick;
    s_valid = 1'b0;
    check("txoff_b0", data_out, 64'h7FFF_FFFF_FFFF_FFFF);
    tick;
    check("txoff_b1", data_out, 64'hFFFF_FFFF_FFFF_FFFF);
    tx_en = 1'b0;
    tick;
    check("txoff_b2", data_out, 64'hFFFF_FFFF_FFFF_FFFF);
    check("txoff_b2_busy", busy, 1'b1);
    tick;
    check("txoff_b3", data_out, 64'hFFFF_FFFF_FFFF_F000);
    check("txoff_b3_sof", sof_out, 1'b0);
    s_valid = 1'b1;
    #1;
    check("txoff_end_s_ready", s_ready, 1'b0);
    tick;
    check("off_sof", sof_out, 1'b0);
    check("off_data", data_out, 64'h0);
    check("off_busy", busy, 1'b0);
    check("off_state", dbg_state, 1'b0);
    ctrl_req = 1'b1; ctrl_code = 8'hA5;
    tick;
    check("off2_data", data_out, 64'h0);
    check("off2_ctrl_ack", ctrl_ack, 1'b0);
    check("off2_s_ready", s_ready, 1'b0);

    // start-up with a control request pending beats the held data request
    tx_en = 1'b1;
    #1;
    check("start_ctrl_ack", ctrl_ack, 1'b1);
    check("start_s_ready", s_ready, 1'b0);
    tick;
    ctrl_req = 1'b0; s_valid = 1'b0;
    check("start_sof", sof_out, 1'b1);
    check("start_b0", data_out, 64'hA940_0000_0000_0000);
    check("start_busy", busy, 1'b1);
`ifdef RIFL_TX_SCHED_STATS_EN
    check("stat_data", stat_data, 32'd4);
    check("stat_ctrl", stat_ctrl, 32'd3);
    check("stat_idle", stat_idle, 32'd4);
`endif

    // reset in the middle of a frame abandons it
    tick;
    check("mid_b1", data_out, 64'h0);
    rst_n = 1'b0;
    tick;
    check("midrst_sof", sof_out, 1'b0);
    check("midrst_data", data_out, 64'h0);
    check("midrst_busy", busy, 1'b0);
`ifdef RIFL_TX_SCHED_STATS_EN
    check("midrst_stat_ctrl", stat_ctrl, 32'd0);
`endif

    // single-beat frames: one decision and one sof per cycle
    tx_en1 = 1'b1; s_valid1 = 1'b1; s_data1 = ones;
    tick; tick;
    check("w_rst_sof", sof_out1, 1'b0);
    check("w_rst_s_ready", s_ready1, 1'b0);
    rst_n1 = 1'b1;
    #1;
    check("w_s_ready0", s_ready1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("w_sof", sof_out1, 1'b1);
      check("w_data", data_out1, full_ones);
      check("w_busy", busy1, 1'b1);
      check("w_s_ready", s_ready1, 1'b1);
    end
    s_valid1 = 1'b0;
    #1;
    check("w_idle_s_ready", s_ready1, 1'b0);
    tick;
    check("w_idle_sof", sof_out1, 1'b1);
    check("w_idle_data", data_out1, full_idle);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rifl_tx_frame_sched.md
# rifl_tx_frame_sched

Transmit-side frame scheduler for the RIFL link, placed directly upstream of the TX scramble controller. At every frame boundary it picks one frame type by fixed priority: control, then user data, then idle. It builds the frame header and payload, then serializes the frame into `FRAME_WIDTH/DWIDTH` bus beats. It drives the `sof` pulse the scrambler uses to track beat position, and leaves the CRC field zeroed for downstream insertion.

## Interface
- `FRAME_WIDTH`, default 256: frame size in bits; must be an integer multiple of `DWIDTH`.
- `DWIDTH`, default 64: output beat width.
- `CRC_WIDTH`, default 12: CRC field width, frame bits [CRC_WIDTH-1:0].
- `CTRL_W`, default 8: control code width; must satisfy `CTRL_W <= PAYLOAD_W`.
- Derived: `PAYLOAD_W = FRAME_WIDTH-2-CRC_WIDTH`.
- Derived: `BEATS = FRAME_WIDTH/DWIDTH`.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `tx_en`  in  1  link transmit enable.
- `pause`  in  1  remote flow-control pause; blocks data frames only.
- `s_data`  in  PAYLOAD_W  user payload.
- `s_valid`  in  1  payload available.
- `s_ready`  out  1  payload accepted this cycle (combinational).
- `ctrl_req`  in  1  control frame request; level, held until acked.
- `ctrl_code`  in  CTRL_W  control code; 0 is reserved for idle.
- `ctrl_ack`  out  1  control request accepted this cycle (combinational).
- `sof_out`  out  1  registered; high on beat 0 of each frame.
- `data_out`  out  DWIDTH  registered frame beat.
- `busy`  out  1  registered; high while state is RUN.

## Operation
- **States:** OFF and RUN. `bcnt` (range 0..BEATS-1) is the index of the beat being registered this cycle.
- **Decision cycle D:**
  - `(OFF && tx_en) || (RUN && bcnt==BEATS-1 && tx_en)`.
  - At D, state becomes or stays RUN and `bcnt` wraps to 0.
- **Priority at D:**
  - `ctrl_req` → control frame, `ctrl_ack=1`.
  - Else `s_valid && !pause` → data frame, `s_ready=1`.
  - Else idle frame.
  - `s_ready` and `ctrl_ack` are never high outside D, and never both high in the same cycle.
- **Frame layout:** MSB first.
  - Bits [FW-1:FW-2] carry the header: data = 2'b01; control and idle = 2'b10.
  - Bits [FW-3:CRC_WIDTH] carry the payload:
    - data frame: `s_data`;
    - control frame: `{ctrl_code, zeros}`;
    - idle frame: all zeros.
  - Bits [CRC_WIDTH-1:0] are 0.
- **Beat order:** beat k carries frame bits [FW-1-k·DWIDTH : FW-(k+1)·DWIDTH].
- **Capture:** the selected frame is latched into a FRAME_WIDTH shift register at D. Beat 0 is driven into the output register the same cycle; the remaining beats shift out on following cycles.
- **tx_en low:**
  - In RUN, a frame in progress always completes.
  - At `bcnt==BEATS-1` with `tx_en=0`, the state goes to OFF.
  - In OFF, `data_out=0`, `sof_out=0`, and no acks are issued.
- **Pause:** `pause` asserted mid-frame affects only the next D; the current frame completes.
- **Control precedence:** `ctrl_req` still wins over data while `pause=1`.
- **BEATS==1:** every cycle in RUN is a decision cycle, giving one frame per cycle.

## Timing
- **Reset:** state OFF, `bcnt=0`, `sof_out=0`, `data_out=0`, `busy=0`. Reset mid-frame abandons the frame immediately.
- **Latency:** decision at cycle t → `sof_out=1` with beat 0 at t+1, beat k at t+1+k.
- **Throughput:** frames are back-to-back while `tx_en` is held; `sof_out` pulses every BEATS cycles with no gaps.
- **Start-up:** `tx_en` rising with state OFF at cycle t → first `sof_out` at t+1.
- **Ack timing:** `s_ready` and `ctrl_ack` are asserted in cycle D only, so the requester drops or advances on the next edge.

## Configuration
- **`RIFL_TX_SCHED_STATS_EN`, defined:**
  - Adds 32-bit outputs `stat_data`, `stat_ctrl` and `stat_idle`.
  - Each counter increments at D for the chosen type.
  - Counters wrap at 2^32 and clear on reset.
- **Macro undefined:** the ports and counters are absent; all other behaviour is identical.

## Structure
- **Shared package `rifl_pkg`:**
  - `HDR_DATA=2'b01` and `HDR_CTRL=2'b10`.
  - `CTRL_IDLE='0`.
  - Frame-type enum `{FT_IDLE, FT_DATA, FT_CTRL}`.
  - State enum `{ST_OFF, ST_RUN}`.
- **Sub-module `rifl_frame_serializer`:**
  - Holds the FRAME_WIDTH load/shift register, the beat counter and `sof` generation.
  - Interface: `load`, `frame`, `beat`, `sof`.
- **Top level:** holds the FSM, the priority logic and the optional statistics counters.

## Test plan
Defaults: FW=256, DW=64, CRC=12, PAYLOAD_W=242.
- **Reset:** hold `rst_n=0` for 3 cycles with `tx_en=1` → all outputs 0. The first `sof_out` appears 1 cycle after `rst_n` rises, carrying an idle frame: beat 0 = 64'h8000_0000_0000_0000.
- **Data frame:** `s_valid=1`, `s_data={242{1'b1}}` → `s_ready` pulses once. Beat 0 = 64'h7FFF_FFFF_FFFF_FFFF, beats 1–2 = all ones, beat 3 = 64'hFFFF_FFFF_FFFF_F000.
- **Simultaneous control and data:** `ctrl_req` with code 8'hA5 and `s_valid` both high → `ctrl_ack` pulses and `s_ready` stays low. Beat 0 = 64'hA940_0000_0000_0000. The data frame follows exactly 4 cycles later.
- **Pause:** `pause=1` with `s_valid=1` for 12 cycles → 3 idle frames and no `s_ready`. Releasing pause → data is accepted at the next boundary.
- **tx_en drop:** `tx_en=0` at beat 1 → beats 2–3 still emitted, then outputs stay 0 and `busy=0`.
- **Statistics (STATS_EN):** 5 data, 2 control and 3 idle frames → `stat_data=5`, `stat_ctrl=2`, `stat_idle=3`. Also run the data-frame scenario with DW=256 (BEATS=1) and check one `sof_out` per cycle.
